scoreboard_core: RTL and testbench
==================================

Name: scoreboard_core

Overview:
- Parametrised successor to the 4-digit button scoreboard.
- Holds N_DIGITS independent counter digits, each stepped by its own push button. Digits are hex or BCD, with optional carry/borrow ripple, synchronous clear and debounced inputs.
- Drives a time-multiplexed 7-segment display with per-digit decimal point and blanking.
- Sits between the board buttons/switches and the AN/SEG pins.

Parameters:
- N_DIGITS, 4, number of digits/buttons/anodes (1..8).
- BCD_MODE, 0, 0 = digits count 0..15 (hex); 1 = digits count 0..9.
- CARRY_EN, 0, 1 = a wrapping digit carries or borrows into the next-higher digit.
- DEBOUNCE_CYC, 250000, cycles a synchronised input must be stable before it is accepted (>=2).
- SCAN_DIV, 50000, clock cycles each digit is displayed (>=1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- btn  in  N_DIGITS  raw push buttons, active-high, asynchronous; btn[i] steps digit i
- dir  in  1  raw switch: 0 = increment, 1 = decrement
- clr  in  1  raw switch/button: clear all digits
- point  in  N_DIGITS  decimal-point enable per digit, active-high
- blank  in  N_DIGITS  blank digit i (all segments off), active-high
- num  out  4*N_DIGITS  current count, digit i in num[4i+3:4i]
- AN  out  N_DIGITS  anode select, active-low, one-hot-low
- SEG  out  8  segments, active-low: SEG[0]=a … SEG[6]=g, SEG[7]=dp

Behaviour:
- Reset: async assert on rst_n low. Clears num=0, AN=all ones, SEG=8'hFF, scan index=0, scan counter=0, all synchronisers, debounce counters and debounced states.
- Input path: btn, dir and clr each pass through a 2-flop synchroniser.
  - btn and clr are then debounced. The debounced state takes the synchronised value only after it has differed from the debounced state for DEBOUNCE_CYC consecutive cycles. Any bounce restarts the count.
  - dir is synchronised only.
- Step pulse: one-cycle pulse on each 0->1 transition of a debounced btn[i]. Holding a button produces exactly one step.
- Latency: num changes on the clock edge after the pulse, i.e. DEBOUNCE_CYC+3 cycles after a clean input edge (bench tolerance ±1).
- Digit arithmetic:
  - Radix R = 10 if BCD_MODE, else 16.
  - Per cycle, digit i gets delta d_i = +1/-1/0 (pulse with dir=0 / dir=1 / none), plus carry-in c_i from digit i-1 (c_0 = 0).
  - New digit = (v+d_i+c_i) mod R; c_(i+1) = floor((v+d_i+c_i)/R), in range -1..+1.
  - If CARRY_EN=0, all c_i = 0.
  - Carry/borrow out of the top digit is discarded (whole counter wraps).
  - All digits update in the same cycle; the ripple is combinational.
  - Simultaneous pulses on several digits are all applied.
- Wrap examples:
  - Hex: F+1=0, 0-1=F.
  - BCD: 9+1=0, 0-1=9.
  - BCD/carry: 0099+1=0100, 0000-1=9999.
- Clear: while debounced clr is high, num <= 0 every cycle; clear has priority over all step pulses in that cycle.
- Display scan:
  - Scan counter counts 0..SCAN_DIV-1; at terminal count the scan index advances, wrapping N_DIGITS-1 -> 0.
  - AN and SEG are registered from the current index each cycle; first valid frame is 1 cycle after reset release (AN[0]=0).
  - SEG[6:0] = hex-to-7seg of digit[idx], active-low (0->7'h40, 1->7'h79, 8->7'h00, F->7'h0E). SEG[7] = ~point[idx].
  - blank[idx]=1 forces SEG=8'hFF; AN still cycles.
- dir changes take effect on the next pulse; dir is not latched per press.

Test Plan:
- Reset (params 4,0,0,4,4): hold rst_n=0 then release -> num=16'h0000, AN=4'b1110 and SEG=8'hC0 one cycle later; AN advances to 4'b1101 after 4 cycles, wraps back to 4'b1110 after 16.
- Debounce: btn[0] toggles every 2 cycles for 20 cycles, then holds high -> num changes once, to 16'h0001, DEBOUNCE_CYC+3 cycles after the final edge; holding btn[0] for 100 cycles gives no further change.
- Hex wrap, no carry: 16 presses of btn[1], dir=0 -> num 16'h0000 -> ... -> 16'h00F0 -> 16'h0000; one press with dir=1 -> 16'h00F0.
- BCD+carry (BCD_MODE=1, CARRY_EN=1): preload 0099 via presses; press btn[0] -> 16'h0100. From 0000 with dir=1, press btn[0] -> 16'h9999.
- Simultaneous: BCD+carry at 0009, btn[0] and btn[1] pressed same cycle, dir=0 -> 16'h0020. Same cycle with clr high -> 16'h0000.
- Blank/point: num=16'h1234, point=4'b0001, blank=4'b0100 -> idx0 SEG=8'h19 (digit 4 with dp on), idx2 SEG=8'hFF, idx1 SEG=8'hB0; assert rst_n low mid-scan -> AN=4'hF and SEG=8'hFF immediately.

Source files
------------

// File: rtl/scoreboard_core_if.sv
// Board-side signal bundle for scoreboard_core: raw buttons and switches in,
// count and multiplexed 7-segment drive out.
interface scoreboard_core_if #(
    parameter int N_DIGITS = 4
);
    logic [N_DIGITS-1:0]   btn;
    logic                  dir;
    logic                  clr;
    logic [N_DIGITS-1:0]   point;
    logic [N_DIGITS-1:0]   blank;
    logic [4*N_DIGITS-1:0] num;
    logic [N_DIGITS-1:0]   AN;
    logic [7:0]            SEG;

    modport master (
        output btn, dir, clr, point, blank,
        input  num, AN, SEG
    );

    modport slave (
        input  btn, dir, clr, point, blank,
        output num, AN, SEG
    );
endinterface

// File: rtl/scoreboard_core.sv
// N-digit push-button counter (hex or BCD, optional carry ripple) with
// synchronised/debounced inputs and a time-multiplexed 7-segment driver.
module scoreboard_core #(
    parameter int N_DIGITS     = 4,
    parameter int BCD_MODE     = 0,
    parameter int CARRY_EN     = 0,
    parameter int DEBOUNCE_CYC = 250000,
    parameter int SCAN_DIV     = 50000
) (
    input  logic                clk,
    input  logic                rst_n,
    scoreboard_core_if.slave    bus
);
    localparam int NB = N_DIGITS + 1;  // debounced lines: buttons plus clr
    localparam int CW = $clog2(DEBOUNCE_CYC + 1);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic signed [5:0] RADIX = (BCD_MODE != 0) ? 6'sd10 : 6'sd16;

    logic [NB-1:0]         r_sync1, r_sync2, r_deb;
    logic [N_DIGITS-1:0]   r_btn_q;
    logic [CW-1:0]         r_cnt [NB];
    logic                  r_dir_s1, r_dir_s2;
    logic [4*N_DIGITS-1:0] r_num;
    logic [SW-1:0]         r_scan_cnt;
    logic [IW-1:0]         r_idx;
    logic [N_DIGITS-1:0]   r_an;
    logic [7:0]            r_seg;

    logic [N_DIGITS-1:0]   w_step;
    logic                  w_clr;
    logic [4*N_DIGITS-1:0] w_num_next;
    logic signed [5:0]     w_sum;
    logic signed [1:0]     w_carry;
    logic [3:0]            w_digit;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
        endcase
    endfunction

    // NOTE: r_cnt is a small register array, not a RAM, so it is reset like
    // any other flop; a real memory would be left unreset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_deb    <= '0;
            r_btn_q  <= '0;
            r_dir_s1 <= 1'b0;
            r_dir_s2 <= 1'b0;
            for (int i = 0; i < NB; i++) r_cnt[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the
            // pre-edge value, which is what makes the 2-flop chain a chain.
            r_sync1  <= {bus.clr, bus.btn};
            r_sync2  <= r_sync1;
            r_dir_s1 <= bus.dir;
            r_dir_s2 <= r_dir_s1;
            r_btn_q  <= r_deb[N_DIGITS-1:0];
            for (int i = 0; i < NB; i++) begin
                if (r_sync2[i] != r_deb[i]) begin
                    if (r_cnt[i] == CW'(DEBOUNCE_CYC - 1)) begin
                        r_deb[i] <= r_sync2[i];
                        r_cnt[i] <= '0;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + 1'b1;
                    end
                end else begin
                    r_cnt[i] <= '0;  // any bounce back restarts the count
                end
            end
        end
    end

    assign w_step = r_deb[N_DIGITS-1:0] & ~r_btn_q;
    assign w_clr  = r_deb[N_DIGITS];

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_num_next = r_num;
        w_carry    = 2'sd0;
        w_sum      = 6'sd0;
        for (int i = 0; i < N_DIGITS; i++) begin
            w_sum = $signed({2'b00, r_num[4*i +: 4]}) + 6'(w_carry);
            if (w_step[i]) w_sum = r_dir_s2 ? w_sum - 6'sd1 : w_sum + 6'sd1;
            if (w_sum < 6'sd0) begin
                w_sum   = w_sum + RADIX;
                w_carry = -2'sd1;
            end else if (w_sum >= RADIX) begin
                w_sum   = w_sum - RADIX;
                w_carry = 2'sd1;
            end else begin
                w_carry = 2'sd0;
            end
            if (CARRY_EN == 0) w_carry = 2'sd0;
            w_num_next[4*i +: 4] = w_sum[3:0];
        end
    end

    assign w_digit = r_num[4*int'(r_idx) +: 4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_num      <= '0;
            r_scan_cnt <= '0;
            r_idx      <= '0;
            r_an       <= '1;
            r_seg      <= 8'hFF;
        end else begin
            r_num <= w_clr ? '0 : w_num_next;
            if (r_scan_cnt == SW'(SCAN_DIV - 1)) begin
                r_scan_cnt <= '0;
                r_idx      <= (r_idx == IW'(N_DIGITS - 1)) ? '0 : r_idx + 1'b1;
            end else begin
                r_scan_cnt <= r_scan_cnt + 1'b1;
            end
            r_an  <= ~(N_DIGITS'(1) << r_idx);
            r_seg <= bus.blank[r_idx] ? 8'hFF : {~bus.point[r_idx], hex7(w_digit)};
        end
    end

    assign bus.num = r_num;
    assign bus.AN  = r_an;
    assign bus.SEG = r_seg;
endmodule

// File: tb/tb_scoreboard_core.sv
// Directed bench for scoreboard_core: a hex/no-carry instance and a BCD/carry
// instance, driven through press/clear vectors plus scan and debounce sequences.
module tb_scoreboard_core;
    localparam int D = 4;
    localparam int S = 4;

    typedef struct {
        int          sel;   // 0 = hex/no-carry instance, 1 = BCD/carry instance
        logic [3:0]  mask;
        logic        dir;
        logic        clr;
        logic [15:0] exp_num;
        string       name;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_bad = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    scoreboard_core_if #(.N_DIGITS(4)) if_a();
    scoreboard_core_if #(.N_DIGITS(4)) if_b();

    scoreboard_core #(.N_DIGITS(4), .BCD_MODE(0), .CARRY_EN(0),
                      .DEBOUNCE_CYC(D), .SCAN_DIV(S))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));

    scoreboard_core #(.N_DIGITS(4), .BCD_MODE(1), .CARRY_EN(1),
                      .DEBOUNCE_CYC(D), .SCAN_DIV(S))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input int sel, input logic [3:0] mask, input logic d, input logic c);
        if (sel == 0) begin
            if_a.btn = mask; if_a.dir = d; if_a.clr = c;
        end else begin
            if_b.btn = mask; if_b.dir = d; if_b.clr = c;
        end
    endtask

    function automatic logic [15:0] get_num(input int sel);
        return (sel == 0) ? if_a.num : if_b.num;
    endfunction

    // Press (and/or clear), hold long enough to debounce, release, settle.
    task automatic press(input vec_t v);
        @(negedge clk);
        drive(v.sel, v.mask, v.dir, v.clr);
        repeat (D + 8) @(negedge clk);
        drive(v.sel, 4'b0000, v.dir, 1'b0);
        repeat (D + 8) @(negedge clk);
        check(v.name, 32'(get_num(v.sel)), 32'(v.exp_num));
    endtask

    initial begin
        logic [3:0]  exp_an;
        logic [15:0] exp_n;
        int          lat;
        bit          changed;
        bit          seen [3];
        logic [7:0]  got_seg [3];

        rst_n = 1'b0;
        if_a.btn = '0; if_a.dir = 1'b0; if_a.clr = 1'b0; if_a.point = '0; if_a.blank = '0;
        if_b.btn = '0; if_b.dir = 1'b0; if_b.clr = 1'b0; if_b.point = '0; if_b.blank = '0;

        // Vector table: hex instance first, then the BCD/carry instance.
        vecs.push_back('{0, 4'b0000, 1'b0, 1'b1, 16'h0000, "a_clear"});
        for (int i = 1; i <= 16; i++) begin
            exp_n = 16'((i % 16) << 4);
            vecs.push_back('{0, 4'b0010, 1'b0, 1'b0, exp_n, $sformatf("a_hex_inc%0d", i)});
        end
        vecs.push_back('{0, 4'b0010, 1'b1, 1'b0, 16'h00F0, "a_hex_dec_wrap"});
        vecs.push_back('{0, 4'b0000, 1'b0, 1'b1, 16'h0000, "a_clear2"});
        vecs.push_back('{0, 4'b1111, 1'b0, 1'b0, 16'h1111, "a_multi_1111"});
        vecs.push_back('{0, 4'b0111, 1'b0, 1'b0, 16'h1222, "a_multi_0111"});
        vecs.push_back('{0, 4'b0011, 1'b0, 1'b0, 16'h1233, "a_multi_0011"});
        vecs.push_back('{0, 4'b0001, 1'b0, 1'b0, 16'h1234, "a_multi_0001"});
        for (int i = 1; i <= 9; i++)
            vecs.push_back('{1, 4'b0001, 1'b0, 1'b0, 16'(i), $sformatf("b_d0_inc%0d", i)});
        for (int i = 1; i <= 9; i++)
            vecs.push_back('{1, 4'b0010, 1'b0, 1'b0, 16'h0009 | 16'(i << 4), $sformatf("b_d1_inc%0d", i)});
        vecs.push_back('{1, 4'b0001, 1'b0, 1'b0, 16'h0100, "b_carry_0099"});
        vecs.push_back('{1, 4'b0000, 1'b0, 1'b1, 16'h0000, "b_clear"});
        vecs.push_back('{1, 4'b0001, 1'b1, 1'b0, 16'h9999, "b_borrow_0000"});
        vecs.push_back('{1, 4'b0000, 1'b0, 1'b1, 16'h0000, "b_clear2"});
        for (int i = 1; i <= 9; i++)
            vecs.push_back('{1, 4'b0001, 1'b0, 1'b0, 16'(i), $sformatf("b_pre_inc%0d", i)});
        vecs.push_back('{1, 4'b0011, 1'b0, 1'b0, 16'h0020, "b_simul_carry"});
        vecs.push_back('{1, 4'b0011, 1'b0, 1'b1, 16'h0000, "b_simul_clr"});

        // Reset state and first scan frames.
        repeat (3) @(negedge clk);
        check("rst_num", 32'(if_a.num), 32'h0);
        check("rst_an", 32'(if_a.AN), 32'hF);
        check("rst_seg", 32'(if_a.SEG), 32'hFF);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            @(posedge clk);
            #1;
            exp_an = ~(4'b0001 << (((k - 1) / S) % 4));
            if (k == 1 || k == 4 || k == 5 || k == 9 || k == 13 || k == 16 || k == 17)
                check($sformatf("scan_an_k%0d", k), 32'(if_a.AN), 32'(exp_an));
            if (k == 1) check("scan_seg_k1", 32'(if_a.SEG), 32'hC0);
        end

        // Debounce: bounce for 20 cycles, then hold high.
        @(negedge clk);
        for (int t = 0; t < 10; t++) begin
            if_a.btn[0] = (t % 2 == 0);
            repeat (2) @(negedge clk);
        end
        check("deb_bounce_no_step", 32'(if_a.num), 32'h0);
        if_a.btn[0] = 1'b1;
        lat = 0;
        changed = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (!changed && if_a.num != 16'h0000) begin
                changed = 1'b1;
                lat = n;
            end
        end
        check("deb_latency_in_window", 32'(lat >= D + 2 && lat <= D + 4), 32'h1);
        check("deb_num", 32'(if_a.num), 32'h0001);
        repeat (100) @(negedge clk);
        check("deb_hold_single_step", 32'(if_a.num), 32'h0001);
        if_a.btn[0] = 1'b0;
        repeat (D + 8) @(negedge clk);

        foreach (vecs[i]) press(vecs[i]);

        // Blank / decimal point on the hex instance holding 1234.
        if_a.point = 4'b0001;
        if_a.blank = 4'b0100;
        for (int i = 0; i < 3; i++) begin seen[i] = 1'b0; got_seg[i] = 8'h00; end
        repeat (2) @(negedge clk);
        for (int n = 0; n < 4 * S; n++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                if (!seen[i] && if_a.AN == ~(4'b0001 << i)) begin
                    seen[i]    = 1'b1;
                    got_seg[i] = if_a.SEG;
                end
            end
        end
        check("disp_idx0_dp", {23'h0, seen[0], got_seg[0]}, {23'h0, 1'b1, 8'h19});
        check("disp_idx1", {23'h0, seen[1], got_seg[1]}, {23'h0, 1'b1, 8'hB0});
        check("disp_idx2_blank", {23'h0, seen[2], got_seg[2]}, {23'h0, 1'b1, 8'hFF});

        // Asynchronous reset in the middle of a scan frame.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_an", 32'(if_a.AN), 32'hF);
        check("async_rst_seg", 32'(if_a.SEG), 32'hFF);
        check("async_rst_num", 32'(if_a.num), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
